// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, threshold flags, error pulses and registered or FWFT read
module sync_fifo_flex #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE = (ASIZE+1)'(AEMPTY_TH);
  logic [DSIZE-1:0] mem_q [2**ASIZE];
  logic [ASIZE:0] wbin_q, wbin_d, rbin_q, rbin_d, count_q, count_d;
  logic wfull_q, wfull_d, rempty_q, rempty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d, wacc, racc;
  always_comb begin
    wacc = wreq & ~wfull_q;
    racc = rreq & ~rempty_q;
    wbin_d = wacc ? wbin_q + 1'b1 : wbin_q;
    rbin_d = racc ? rbin_q + 1'b1 : rbin_q;
    count_d = (wacc & ~racc) ? count_q + 1'b1 : (racc & ~wacc) ? count_q - 1'b1 : count_q;
    wfull_d = count_d == DEPTH;
    rempty_d = count_d == '0;
    afull_d = count_d >= AF;
    aempty_d = count_d <= AE;
    ovf_d = wreq & wfull_q;
    udf_d = rreq & rempty_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q <= '0;
      rbin_q <= '0;
      count_q <= '0;
      wfull_q <= 1'b0;
      rempty_q <= 1'b1;
      afull_q <= AFULL_TH == 0;
      aempty_q <= 1'b1;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      rbin_q <= rbin_d;
      count_q <= count_d;
      wfull_q <= wfull_d;
      rempty_q <= rempty_d;
      afull_q <= afull_d;
      aempty_q <= aempty_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wacc) mem_q[wbin_q[ASIZE-1:0]] <= wdata;
  end
  if (FWFT != 0) begin : g_fwft
    assign rdata = rempty_q ? '0 : mem_q[rbin_q[ASIZE-1:0]];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q, rdata_d;
    always_comb rdata_d = racc ? mem_q[rbin_q[ASIZE-1:0]] : rdata_q;
    always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
    assign rdata = rdata_q;
  end
  assign wfull = wfull_q;
  assign rempty = rempty_q;
  assign walmost_full = afull_q;
  assign ralmost_empty = aempty_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: scoreboard bench driving a registered-read and an FWFT instance in lockstep
module tb_sync_fifo_flex;
  logic clk = 0, rst = 1, wreq = 0, rreq = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rd [2];
  logic [2:0] cnt [2];
  logic wf [2], re [2], af [2], ae [2], ov [2], un [2];
  int n_chk = 0, n_pass = 0;
  logic [7:0] sb [$];
  logic [7:0] last_rd = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sync_fifo_flex #(.DSIZE(8), .ASIZE(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(g)) u_dut (
      .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .rreq(rreq), .rdata(rd[g]),
      .wfull(wf[g]), .rempty(re[g]), .walmost_full(af[g]), .ralmost_empty(ae[g]),
      .count(cnt[g]), .overflow(ov[g]), .underflow(un[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic step(input logic r_st, input logic w, input logic [7:0] d, input logic r);
    logic eo, eu, full, empty;
    int c;
    @(negedge clk);
    rst = r_st;
    wreq = w;
    wdata = d;
    rreq = r;
    @(posedge clk);
    #1;
    if (r_st) begin
      sb.delete();
      last_rd = 0;
      eo = 0;
      eu = 0;
    end else begin
      full = sb.size() == 4;
      empty = sb.size() == 0;
      eo = w && full;
      eu = r && empty;
      if (r && !empty) last_rd = sb.pop_front();
      if (w && !full) sb.push_back(d);
    end
    c = sb.size();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count%0d", i), 32'(cnt[i]), 32'(c));
      chk($sformatf("flags%0d{wf,re,af,ae,ov,un}", i), {26'd0, wf[i], re[i], af[i], ae[i], ov[i], un[i]},
          {26'd0, c == 4, c == 0, c >= 3, c <= 1, eo, eu});
    end
    chk("rdata_reg", 32'(rd[0]), 32'(last_rd));
    if (c != 0) chk("rdata_fwft", 32'(rd[1]), 32'(sb[0]));
  endtask
  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'hA1 + 8'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 8'h55, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hB0 + 8'(i), 0);
    step(0, 1, 8'hC0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'h10 + 8'(i), 0);
      step(0, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 8'hD0 + 8'(i), 0);
    step(1, 1, 8'hEE, 0);
    step(0, 0, 0, 0);
    step(0, 1, 8'h77, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
